// File: rtl/desc_pkg.sv
// ============================================================================
// Module   : desc_pkg
// Brief    : Shared constants, FSM encoding and helpers for the SIFT
//            descriptor sample-coordinate generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package desc_pkg;

    localparam int DESC_WIN   = 16;
    localparam int DESC_NDIR  = 36;
    localparam int DESC_OFF_W = 5;
    localparam int DESC_BIN_W = 4;

    typedef logic [1:0] desc_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Wide enough for any coordinate width up to 15 bits plus sign.
    function automatic logic signed [15:0] sext5(input logic [DESC_OFF_W-1:0] v);
        return {{(16 - DESC_OFF_W){v[DESC_OFF_W-1]}}, v};
    endfunction

endpackage : desc_pkg

`default_nettype wire

// File: rtl/desc_coord_add.sv
// ============================================================================
// Module   : desc_coord_add
// Brief    : Keypoint coordinate + signed rotated offset, with image bounds
//            check. Clamps out-of-range results when DESC_BOUNDS_CLAMP_EN
//            is defined, otherwise wraps to the low COORD_W bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module desc_coord_add #(
    parameter int COORD_W = 10,
    parameter int LIMIT   = 640
) (
    input  logic                      [COORD_W-1:0] kp,
    input  logic signed               [COORD_W:0]   off,
    output logic                      [COORD_W-1:0] coord,
    output logic                                    inb
);

    localparam logic [COORD_W-1:0] c_max = COORD_W'(LIMIT - 1);

    logic signed [COORD_W:0] w_sum;
    logic                    w_neg;
    logic                    w_over;

    assign w_sum  = $signed({1'b0, kp}) + off;
    assign w_neg  = w_sum[COORD_W];
    assign w_over = !w_neg && (w_sum[COORD_W-1:0] > c_max);
    assign inb    = !w_neg && !w_over;

`ifdef DESC_BOUNDS_CLAMP_EN
    assign coord = w_neg  ? '0    :
                   w_over ? c_max : w_sum[COORD_W-1:0];
`else
    assign coord = w_sum[COORD_W-1:0];
`endif

endmodule : desc_coord_add

`default_nettype wire

// File: rtl/desc_sample_scan.sv
// ============================================================================
// Module   : desc_sample_scan
// Brief    : Sweeps the 16x16 descriptor window, drives the rotation ROMs and
//            streams bounds-checked sample coordinates with sub-region bins.
//            Optional clamping via DESC_BOUNDS_CLAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module desc_sample_scan
    import desc_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [COORD_W-1:0]    kp_x,
    input  logic [COORD_W-1:0]    kp_y,
    input  logic [5:0]            kp_dir,
    output logic                  busy,
    output logic                  done,
    output logic [5:0]            rom_dir,
    output logic [7:0]            rom_addr,
    input  logic [DESC_OFF_W-1:0] rom_dx,
    input  logic [DESC_OFF_W-1:0] rom_dy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COORD_W-1:0]    out_x,
    output logic [COORD_W-1:0]    out_y,
    output logic                  out_inb,
    output logic [DESC_BIN_W-1:0] out_bin,
    output logic [7:0]            out_idx,
    output logic                  out_last
);

    localparam logic [7:0] c_last = 8'(DESC_WIN * DESC_WIN - 1);

    desc_state_t           r_state;
    logic [7:0]            r_cnt;
    logic [COORD_W-1:0]    r_kp_x;
    logic [COORD_W-1:0]    r_kp_y;
    logic [5:0]            r_dir;
    logic                  r_done;

    logic                  r_s1_v;
    logic signed [COORD_W:0] r_s1_dx;
    logic signed [COORD_W:0] r_s1_dy;
    logic [7:0]            r_s1_idx;

    logic                  r_out_valid;
    logic [COORD_W-1:0]    r_out_x;
    logic [COORD_W-1:0]    r_out_y;
    logic                  r_out_inb;
    logic [DESC_BIN_W-1:0] r_out_bin;
    logic [7:0]            r_out_idx;
    logic                  r_out_last;

    logic                  w_adv;
    logic                  w_start;
    logic                  w_acc_last;
    logic [COORD_W-1:0]    w_x;
    logic [COORD_W-1:0]    w_y;
    logic                  w_inb_x;
    logic                  w_inb_y;

    // A single enable stalls counter and both stages together, so nothing
    // in flight is lost or repeated under backpressure.
    assign w_adv      = !r_out_valid || out_ready;
    assign w_start    = start && (r_state == ST_IDLE) && !r_done;
    assign w_acc_last = r_out_valid && out_ready && r_out_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_kp_x  <= '0;
            r_kp_y  <= '0;
            r_dir   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_acc_last;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_SCAN;
                        r_cnt   <= '0;
                        r_kp_x  <= kp_x;
                        r_kp_y  <= kp_y;
                        r_dir   <= kp_dir;
                    end
                end
                ST_SCAN: begin
                    if (w_adv) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == c_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_acc_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v   <= 1'b0;
            r_s1_dx  <= '0;
            r_s1_dy  <= '0;
            r_s1_idx <= '0;
        end else if (w_adv) begin
            r_s1_v   <= (r_state == ST_SCAN);
            r_s1_dx  <= (COORD_W + 1)'(sext5(rom_dx));
            r_s1_dy  <= (COORD_W + 1)'(sext5(rom_dy));
            r_s1_idx <= r_cnt;
        end
    end

    desc_coord_add #(
        .COORD_W (COORD_W),
        .LIMIT   (IMG_W)
    ) u_add_x (
        .kp    (r_kp_x),
        .off   (r_s1_dx),
        .coord (w_x),
        .inb   (w_inb_x)
    );

    desc_coord_add #(
        .COORD_W (COORD_W),
        .LIMIT   (IMG_H)
    ) u_add_y (
        .kp    (r_kp_y),
        .off   (r_s1_dy),
        .coord (w_y),
        .inb   (w_inb_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_inb   <= 1'b0;
            r_out_bin   <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_v;
            r_out_x     <= w_x;
            r_out_y     <= w_y;
            r_out_inb   <= w_inb_x && w_inb_y;
            r_out_bin   <= {r_s1_idx[7:6], r_s1_idx[3:2]};
            r_out_idx   <= r_s1_idx;
            r_out_last  <= r_s1_v && (r_s1_idx == c_last);
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign rom_dir   = r_dir;
    assign rom_addr  = r_cnt;
    assign out_valid = r_out_valid;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_inb   = r_out_inb;
    assign out_bin   = r_out_bin;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

endmodule : desc_sample_scan

`default_nettype wire

// File: tb/tb_desc_sample_scan.sv
// ============================================================================
// Module   : tb_desc_sample_scan
// Brief    : Self-checking bench for desc_sample_scan with a behavioural
//            sample model, ROM model and directed scans.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_desc_sample_scan;

    localparam int COORD_W = 10;
    localparam int IMG_W   = 640;
    localparam int IMG_H   = 480;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [9:0]   kp_x = '0;
    logic [9:0]   kp_y = '0;
    logic [5:0]   kp_dir = '0;
    logic         busy, done, out_valid, out_inb, out_last;
    logic         out_ready = 1'b1;
    logic [5:0]   rom_dir;
    logic [7:0]   rom_addr, out_idx;
    logic [4:0]   rom_dx, rom_dy;
    logic [9:0]   out_x, out_y;
    logic [3:0]   out_bin;

    desc_sample_scan #(
        .COORD_W (COORD_W),
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .kp_x      (kp_x),
        .kp_y      (kp_y),
        .kp_dir    (kp_dir),
        .busy      (busy),
        .done      (done),
        .rom_dir   (rom_dir),
        .rom_addr  (rom_addr),
        .rom_dx    (rom_dx),
        .rom_dy    (rom_dy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_inb   (out_inb),
        .out_bin   (out_bin),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ROM contents: dy 3,2,1,0 at idx 0..3, both offsets -1 at idx 4,
    // otherwise a direction-dependent pattern.
    function automatic logic [4:0] romdy(input int a, input int d);
        int t;
        if (a < 4)       t = 3 - a;
        else if (a == 4) t = 31;
        else             t = (a * 7 + d) % 32;
        return t[4:0];
    endfunction

    function automatic logic [4:0] romdx(input int a, input int d);
        int t;
        if (a == 4) t = 31;
        else        t = (a * 3 + d * 5) % 32;
        return t[4:0];
    endfunction

    always_comb begin
        rom_dx = romdx(int'(rom_addr), int'(rom_dir));
        rom_dy = romdy(int'(rom_addr), int'(rom_dir));
    end

    function automatic int off5(input logic [4:0] o);
        return o[4] ? int'(o) - 32 : int'(o);
    endfunction

    function automatic int exp_coord(input int s, input int lim);
`ifdef DESC_BOUNDS_CLAMP_EN
        if (s < 0)        return 0;
        else if (s >= lim) return lim - 1;
        else              return s;
`else
        return s & ((1 << COORD_W) - 1);
`endif
    endfunction

    function automatic bit exp_inb(input int s, input int lim);
        return (s >= 0) && (s < lim);
    endfunction

    // ---------------- model + compare process ----------------
    int          m_x, m_y, m_dir;
    int          exp_k = 0;
    bit          prev_stall = 1'b0;
    logic [34:0] prev_vec, cur_vec;
    int          cap_x[256], cap_y[256], cap_inb[256], cap_bin[256];

    always @(negedge clk) begin
        int sx, sy;
        cur_vec = {out_valid, out_x, out_y, out_inb, out_bin, out_idx, out_last};
        if (rst) begin
            exp_k      = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("held_while_stalled", cur_vec, prev_vec);
            if (out_valid) begin
                if (exp_k > 255) begin
                    chk("extra_beat", exp_k, 255);
                end else begin
                    sx = m_x + off5(romdx(exp_k, m_dir));
                    sy = m_y + off5(romdy(exp_k, m_dir));
                    chk("idx",  out_idx,  exp_k);
                    chk("last", out_last, (exp_k == 255));
                    chk("bin",  out_bin,  (exp_k / 64) * 4 + (exp_k % 16) / 4);
                    chk("x",    out_x,    exp_coord(sx, IMG_W));
                    chk("y",    out_y,    exp_coord(sy, IMG_H));
                    chk("inb",  out_inb,  exp_inb(sx, IMG_W) && exp_inb(sy, IMG_H));
                    if (out_ready) begin
                        cap_x[exp_k]   = int'(out_x);
                        cap_y[exp_k]   = int'(out_y);
                        cap_inb[exp_k] = int'(out_inb);
                        cap_bin[exp_k] = int'(out_bin);
                        exp_k++;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_vec   = cur_vec;
            if (done) begin
                chk("beats_at_done", exp_k, 256);
                exp_k = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_scan(input int x, input int y, input int d, input bit rnd,
                            input bit midstart, input bit timing, input int abort_at);
        int first  = -1;
        int done_n = -1;
        int n      = 0;
        m_x = x; m_y = y; m_dir = d;
        kp_x = 10'(x); kp_y = 10'(y); kp_dir = 6'(d);
        out_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        while (n < 3000) begin
            if (out_valid && first < 0) first = n;
            if (done) begin
                done_n = n;
                break;
            end
            if (abort_at >= 0 && exp_k >= abort_at) break;
            if (midstart && n == 50) begin
                start = 1'b1; kp_x = 10'd1; kp_y = 10'd2; kp_dir = 6'd33;
            end
            if (midstart && n == 51) begin
                start = 1'b0; kp_x = 10'(x); kp_y = 10'(y); kp_dir = 6'(d);
            end
            if (midstart && n == 60) chk("rom_dir_stable", rom_dir, d);
            if (rnd) out_ready = ($urandom_range(0, 9) >= 3);
            tick;
            n++;
        end
        if (abort_at < 0) begin
            chk("done_seen", (done_n >= 0), 1);
            chk("busy_low_at_done", busy, 0);
            if (timing) begin
                chk("first_valid_latency", first, 2);
                chk("scan_cycles", done_n, 258);
            end
            out_ready = 1'b1;
            tick;
            chk("done_one_cycle", done, 0);
        end else begin
            chk("abort_point_reached", (exp_k >= abort_at), 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        tick; tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_rom_dir", rom_dir, 0);
        chk("rst_out_x", out_x, 0);
        rst = 1'b0;
        tick;

        // Scan 1: no backpressure, timing and literal values.
        run_scan(100, 100, 15, 1'b0, 1'b0, 1'b1, -1);
        chk("lit_y0", cap_y[0], 103);
        chk("lit_y1", cap_y[1], 102);
        chk("lit_y2", cap_y[2], 101);
        chk("lit_y3", cap_y[3], 100);
        chk("lit_y4", cap_y[4], 99);
        chk("lit_bin_5a", cap_bin[8'h5A], 4'b0110);

        // Scan 2: origin keypoint, negative offsets go out of bounds.
        run_scan(0, 0, 3, 1'b1, 1'b0, 1'b0, -1);
        chk("lit_origin_inb4", cap_inb[4], 0);
`ifdef DESC_BOUNDS_CLAMP_EN
        chk("lit_origin_x4", cap_x[4], 0);
`else
        chk("lit_origin_x4", cap_x[4], 1023);
`endif

        // Scan 3: near the far corner, with a start pulse mid-scan.
        run_scan(630, 470, 35, 1'b1, 1'b1, 1'b0, -1);
        chk("lit_corner_inb0", cap_inb[0], 0);
`ifdef DESC_BOUNDS_CLAMP_EN
        chk("lit_corner_x0", cap_x[0], 639);
`else
        chk("lit_corner_x0", cap_x[0], 645);
`endif
        chk("lit_corner_y0", cap_y[0], 473);

        // Scan 4: asynchronous reset at beat 100, then clean restart.
        run_scan(200, 150, 7, 1'b1, 1'b0, 1'b0, 100);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_rom_addr", rom_addr, 0);
        chk("async_rst_rom_dir", rom_dir, 0);
        chk("async_rst_out_x", out_x, 0);
        chk("async_rst_out_idx", out_idx, 0);
        tick; tick;
        rst = 1'b0;
        tick;
        run_scan(300, 200, 20, 1'b1, 1'b0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_desc_sample_scan

`default_nettype wire

// File: doc/desc_sample_scan.md
# desc_sample_scan

Sample-coordinate generator for the SIFT descriptor stage. For each keypoint it sweeps the 16×16 descriptor window and drives the per-orientation rotation ROMs (`dirNN_1`/`dirNN_2`: 8-bit address, 5-bit two's-complement offset). It adds the returned rotated offsets to the keypoint centre and streams bounds-checked pixel coordinates, tagged with a 4×4 sub-region bin, to the gradient-fetch / histogram stage downstream.

## Interface
- `COORD_W`, default 10: keypoint/pixel coordinate width (unsigned).
- `IMG_W`, default 640: image width in pixels.
- `IMG_H`, default 480: image height in pixels.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a scan; sampled only while idle.
- `kp_x`, `kp_y` in COORD_W: keypoint centre, captured on accepted `start`.
- `kp_dir` in 6: orientation index 0..35, captured on accepted `start`.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse after the last beat is accepted.
- `rom_dir` out 6: selects the ROM pair (external mux).
- `rom_addr` out 8: {row[3:0], col[3:0]}.
- `rom_dx`, `rom_dy` in 5: combinational ROM data for `rom_addr`, two's complement (0x1f = −1).
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `out_x`, `out_y` out COORD_W: sample pixel coordinate.
- `out_inb` out 1: sample lies inside the image.
- `out_bin` out 4: {row[3:2], col[3:2]}.
- `out_idx` out 8: window index (= ROM address of this sample).
- `out_last` out 1: asserted with idx 255.

## Operation
- FSM states: IDLE, SCAN, DRAIN.
  - IDLE → SCAN on `start`: latch `kp_*`; set the counter to 0.
  - SCAN: the counter drives `rom_addr`. On each advance it increments; on advance at 255 → DRAIN.
  - DRAIN → IDLE when the beat carrying `out_last` is accepted. `done` pulses on that same cycle.
- `start` while busy is ignored.
- Pipeline:
  - S1 registers sext(`rom_dx`), sext(`rom_dy`) and idx.
  - S2 computes x = kp_x + dx and y = kp_y + dy in signed COORD_W+1 bits.
  - `out_inb` = (0 ≤ x ≤ IMG_W−1) && (0 ≤ y ≤ IMG_H−1).
- Global advance enable: `adv` = !out_valid || out_ready. Counter, S1 and S2 all hold when `adv`=0. No beat is dropped or duplicated.
- `rom_dir` = latched kp_dir; it is stable for the whole scan.
- Reset (asynchronous, any time, including mid-scan):
  - FSM → IDLE, counter and pipeline valids cleared.
  - All outputs 0, except `rom_dir` and `rom_addr`, which also reset to 0.

## Timing
- `start` accepted at edge E0. The first `out_valid` appears after edge E0+2, with no backpressure.
- Throughput is 1 sample/cycle. A full scan is 256 beats; `busy` is high from E0 until after the `done` edge (258 cycles minimum).
- `out_*` are registered and stable while `out_valid && !out_ready`.
- A new `start` is accepted at the earliest on the cycle after `done`.

## Configuration
- `DESC_BOUNDS_CLAMP_EN`
  - Defined: out-of-bounds x/y are clamped to [0, IMG_W−1] / [0, IMG_H−1]. `out_inb` still reports 0 for such samples.
  - Undefined: `out_x`/`out_y` are the truncated low COORD_W bits of the sum (wrap-around), with `out_inb`=0. This mode is for downstream stages that mask OOB samples themselves.

## Structure
- Package `desc_pkg`:
  - `DESC_WIN`=16, `DESC_NDIR`=36, offset width 5, bin width 4.
  - FSM state typedef.
  - A `sext5` function.
- Sub-module `desc_coord_add`: combinational add + bounds check + optional clamp. It is instantiated once for x and once for y.

## Test plan
- kp=(100,100), dir 15, ROM model returns dy of 3, 2, 1, 0 at idx 0..3 → `out_y` = 103, 102, 101, 100; first `out_valid` 2 cycles after `start`; `done` after 256 beats.
- idx 4 with dy=0x1f → `out_y`=99. idx 0x5A → `out_bin`=4'b0110, `out_idx`=0x5A.
- kp=(0,0), dx=−1 at idx 4:
  - `out_inb`=0.
  - `out_x`=0 with `DESC_BOUNDS_CLAMP_EN` defined.
  - `out_x`=1023 without it.
- Random `out_ready` toggling (30% low) → exactly 256 beats, idx 0..255 in order, outputs held while stalled, `out_last` only on 255.
- `start` pulsed mid-scan → ignored; latched kp unchanged.
- `rst` asserted at beat 100 → all outputs 0 asynchronously; next `start` restarts cleanly at idx 0.
